// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-bit synchronous FIFO and its read-side engine.
package fifo_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH,
    DONE
  } rd_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order stream buffer: push to tail, pop from head, head visible combinationally.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic [DW-1:0] head_data,
  output logic          head_last
);

  logic [DW-1:0] data0, data1;
  logic          last0, last1;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ   <= '0;
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data1 <= push_data;
            last1 <= push_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= push_data;
            last1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = data0;
  assign head_last = last0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a fixed-length burst from the FIFO and streams it out on valid/ready with last.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DW,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  read_en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  rd_state_t state, state_next;

  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  captured;
  logic                  inflight;

  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic                  byte_last;
  logic                  xfer;
  logic                  buf_push;
  logic                  buf_pop;
  logic [2:0]            committed;
  logic                  credit_ok;

  // The returning FIFO byte is presented directly when the buffer is empty;
  // it enters the buffer only if it is not accepted in its arrival cycle.
  assign byte_last = inflight && ((captured + LEN_WIDTH'(1)) == remaining);
  assign m_valid   = (occ != 2'd0) || inflight;
  assign m_data    = (occ != 2'd0) ? head_data : (inflight ? data_out : '0);
  assign m_last    = (occ != 2'd0) ? head_last : byte_last;
  assign xfer      = m_valid && m_ready;
  assign buf_pop   = xfer && (occ != 2'd0);
  assign buf_push  = inflight && !((occ == 2'd0) && m_ready);
  assign committed = {1'b0, occ} + {2'b00, inflight};
  assign credit_ok = committed < (3'd2 + {2'b00, xfer});

  skid_buf2 #(
    .DW(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (buf_push),
    .push_data(data_out),
    .push_last(byte_last),
    .pop      (buf_pop),
    .occ      (occ),
    .head_data(head_data),
    .head_last(head_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Burst length, pop/capture counters and the one-deep in-flight flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      issued    <= '0;
      captured  <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= read_en;
      if (state == IDLE && start) begin
        remaining <= burst_len;
        issued    <= '0;
        captured  <= '0;
      end else begin
        if (read_en)  issued   <= issued + LEN_WIDTH'(1);
        if (inflight) captured <= captured + LEN_WIDTH'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (burst_len == '0) ? DONE : FETCH;
      FETCH: if (read_en && ((issued + LEN_WIDTH'(1)) == remaining)) state_next = FLUSH;
      // Accepting the tagged last byte implies buffer and in-flight slot drain on this edge.
      FLUSH: if (xfer && m_last) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    read_en = !reset && (state == FETCH) && !empty && (issued < remaining) && credit_ok;
  end

endmodule
